// File: rtl/ppu_requant.sv
// Post-processing requantizer: round, shift, optional ReLU and saturate one
// accumulator row per capture, then queue packed rows in a show-ahead FIFO.
module ppu_requant #(
    parameter int ARRAY_SIZE = 4,
    parameter int ACC_W      = 32,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ppu_capture_en,
    input  logic [$clog2(ARRAY_SIZE)-1:0]  ppu_cycle_idx,
    input  logic [ARRAY_SIZE*ACC_W-1:0]    acc_row,
    input  logic [5:0]                     cfg_shift,
    input  logic                           cfg_relu,
    input  logic                           ovf_clr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ARRAY_SIZE*DATA_W-1:0]   out_data,
    output logic [$clog2(ARRAY_SIZE)-1:0]  out_row,
    output logic                           tile_done,
    output logic                           overflow
);
    localparam int IDX_W = $clog2(ARRAY_SIZE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ROW_W = ARRAY_SIZE * DATA_W;
    localparam int ENT_W = ROW_W + IDX_W;

    localparam logic [5:0]         SHIFT_MAX = 6'(ACC_W - 1);
    localparam logic [IDX_W-1:0]   LAST_ROW  = IDX_W'(ARRAY_SIZE - 1);
    localparam logic [CNT_W-1:0]   DEPTH     = CNT_W'(FIFO_DEPTH);
    localparam logic signed [ACC_W:0] RND_ONE = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);

    logic [5:0]       shift_sh;
    logic             relu_sh;
    logic [5:0]       shift_eff;
    logic             relu_eff;
    logic             new_tile;

    logic signed [ACC_W:0] rnd_lane [ARRAY_SIZE];
    logic signed [ACC_W:0] s1_lane  [ARRAY_SIZE];
    logic                  s1_valid;
    logic                  s1_relu;
    logic [IDX_W-1:0]      s1_row;
    logic [ROW_W-1:0]      s2_data;

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic [ENT_W-1:0] head;

    // Row 0 of a tile uses the freshly presented config, so it is bypassed
    // around the shadow registers that it is also loading.
    always_comb begin
        new_tile  = ppu_capture_en && (ppu_cycle_idx == '0);
        shift_eff = shift_sh;
        relu_eff  = relu_sh;
        if (new_tile) begin
            shift_eff = (cfg_shift > SHIFT_MAX) ? SHIFT_MAX : cfg_shift;
            relu_eff  = cfg_relu;
        end
    end

    // Per-lane round-half-up and arithmetic shift in ACC_W+1 bits (no wrap).
    always_comb begin
        logic signed [ACC_W:0] ext;
        ext = '0;
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            ext = $signed({acc_row[j*ACC_W + ACC_W - 1], acc_row[j*ACC_W +: ACC_W]});
            if (shift_eff != 6'd0)
                ext = ext + (RND_ONE <<< (shift_eff - 6'd1));
            rnd_lane[j] = ext >>> shift_eff;
        end
    end

    // Shadow config and stage S1 registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_sh <= '0;
            relu_sh  <= 1'b0;
            s1_valid <= 1'b0;
            s1_relu  <= 1'b0;
            s1_row   <= '0;
        end else begin
            if (new_tile) begin
                shift_sh <= shift_eff;
                relu_sh  <= relu_eff;
            end
            s1_valid <= ppu_capture_en;
            if (ppu_capture_en) begin
                s1_relu <= relu_eff;
                s1_row  <= ppu_cycle_idx;
            end
        end
    end

    // Lane data carries no reset; it is qualified by s1_valid.
    always_ff @(posedge clk) begin
        if (ppu_capture_en)
            for (int j = 0; j < ARRAY_SIZE; j++)
                s1_lane[j] <= rnd_lane[j];
    end

    // Stage S2: optional ReLU then saturate each lane to DATA_W.
    always_comb begin
        logic signed [ACC_W:0] v;
        v       = '0;
        s2_data = '0;
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            v = s1_lane[j];
            if (s1_relu && (v < 0))
                v = '0;
            if (v > SAT_MAX)
                v = SAT_MAX;
            else if (v < SAT_MIN)
                v = SAT_MIN;
            s2_data[j*DATA_W +: DATA_W] = v[DATA_W-1:0];
        end
    end

    // FIFO control; a full FIFO still accepts a push when the head pops.
    always_comb begin
        full      = (count == DEPTH);
        out_valid = (count != '0);
        pop       = out_valid && out_ready;
        push_ok   = s1_valid && (!full || pop);
        drop      = s1_valid && !push_ok;
        head      = mem[rd_ptr];
        out_data  = out_valid ? head[ENT_W-1:IDX_W] : '0;
        out_row   = out_valid ? head[IDX_W-1:0]     : '0;
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {s2_data, s1_row};
    end

    // FIFO pointers, occupancy, tile_done pulse and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            tile_done <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push_ok)
                count <= count - CNT_W'(1);
            tile_done <= pop && (out_row == LAST_ROW);
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ppu_requant.sv
// Directed bench for ppu_requant: expected rows go into a scoreboard queue at
// capture time; a negedge monitor pops and compares each FIFO pop.
module tb_ppu_requant;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ppu_capture_en;
    logic [1:0]  ppu_cycle_idx;
    logic [127:0] acc_row;
    logic [5:0]  cfg_shift;
    logic        cfg_relu;
    logic        ovf_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_row;
    logic        tile_done;
    logic        overflow;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  row;
    } exp_t;

    exp_t sb[$];
    int   vectors       = 0;
    int   miscompares   = 0;
    int   tile_done_cnt = 0;
    bit   td_pending    = 1'b0;

    always #5 clk = ~clk;

    ppu_requant #(.ARRAY_SIZE(4), .ACC_W(32), .DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ppu_capture_en(ppu_capture_en),
        .ppu_cycle_idx(ppu_cycle_idx), .acc_row(acc_row), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .ovf_clr(ovf_clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .tile_done(tile_done), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every pop against the scoreboard, and check that
    // tile_done follows exactly one cycle after a row-3 pop.
    always @(negedge clk) begin
        exp_t e;
        chk("tile_done", {63'd0, tile_done}, {63'd0, td_pending});
        if (tile_done === 1'b1)
            tile_done_cnt++;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_row: got row %0d data %0h expected no row", out_row, out_data);
            end else begin
                e = sb.pop_front();
                chk("row_data", {32'd0, out_data}, {32'd0, e.data});
                chk("row_idx", {62'd0, out_row}, {62'd0, e.row});
            end
            td_pending = (out_row == 2'd3);
        end else begin
            td_pending = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one capture for one cycle; kept rows are queued as expected output.
    task automatic cap(input logic [1:0] idx, input int a0, input int a1, input int a2, input int a3,
                       input logic [5:0] sh, input logic rl, input bit kept,
                       input int e0, input int e1, input int e2, input int e3);
        exp_t t;
        ppu_capture_en = 1'b1;
        ppu_cycle_idx  = idx;
        acc_row        = {a3, a2, a1, a0};
        cfg_shift      = sh;
        cfg_relu       = rl;
        if (kept) begin
            t.data = {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
            t.row  = idx;
            sb.push_back(t);
        end
        step(1);
        ppu_capture_en = 1'b0;
    endtask

    initial begin
        int td_before;
        rst_n = 1'b0; ppu_capture_en = 1'b0; ppu_cycle_idx = '0; acc_row = '0;
        cfg_shift = '0; cfg_relu = 1'b0; ovf_clr = 1'b0; out_ready = 1'b0;
        step(2);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_row", {62'd0, out_row}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        step(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(1);

        // Passthrough with latency check.
        cap(2'd0, 100, -100, 127, -128, 6'd0, 1'b0, 1'b1, 100, -100, 127, -128);
        @(negedge clk);
        chk("lat_early", {63'd0, out_valid}, 64'd0);
        step(1);
        @(negedge clk);
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        step(3);

        // Rounding, saturation, ReLU.
        cap(2'd0, 24, -24, 7, 8, 6'd4, 1'b0, 1'b1, 2, -1, 0, 1);
        cap(2'd0, 1000, -1000, -5, 300, 6'd0, 1'b0, 1'b1, 127, -128, -5, 127);
        cap(2'd0, 1000, -1000, -5, 300, 6'd0, 1'b1, 1'b1, 127, 0, 0, 127);
        step(5);

        // Backpressure: fill, drop one, then drain a whole tile.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            cap(2'(i), i, -i, 50 + i, -50 - i, 6'd0, 1'b0, 1'b1, i, -i, 50 + i, -50 - i);
        step(2);
        @(negedge clk);
        chk("full_no_ovf", {63'd0, overflow}, 64'd0);
        chk("full_valid", {63'd0, out_valid}, 64'd1);
        step(1);
        cap(2'd0, 9, 9, 9, 9, 6'd0, 1'b0, 1'b0, 0, 0, 0, 0);
        step(2);
        @(negedge clk);
        chk("drop_ovf", {63'd0, overflow}, 64'd1);
        td_before = tile_done_cnt;
        step(1);
        out_ready = 1'b1;
        step(8);
        @(negedge clk);
        chk("drain_empty", {63'd0, out_valid}, 64'd0);
        chk("drain_tile_done_cnt", 64'(tile_done_cnt - td_before), 64'd1);
        chk("ovf_sticky", {63'd0, overflow}, 64'd1);
        step(1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_clr", {63'd0, overflow}, 64'd0);
        step(1);

        // Config shadow: mid-tile shift/relu changes ignored, then a
        // back-to-back tile whose row 0 takes the new config.
        cap(2'd0, 400, -400, 10, 6, 6'd2, 1'b0, 1'b1, 100, -100, 3, 2);
        for (int i = 1; i < 4; i++)
            cap(2'(i), 40, -40, 2, 1, 6'd6, 1'b1, 1'b1, 10, -10, 1, 0);
        cap(2'd0, 5, -5, 7, -7, 6'd0, 1'b0, 1'b1, 5, -5, 7, -7);
        step(8);

        // Reset mid-tile with overflow set and rows pending.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            cap(2'(i), 1, 2, 3, 4, 6'd0, 1'b0, 1'b0, 0, 0, 0, 0);
        cap(2'd0, 1, 2, 3, 4, 6'd0, 1'b0, 1'b0, 0, 0, 0, 0);
        cap(2'd1, 1, 2, 3, 4, 6'd0, 1'b0, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst_ovf", {63'd0, overflow}, 64'd1);
        rst_n = 1'b0;
        step(1);
        @(negedge clk);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_data", {32'd0, out_data}, 64'd0);
        chk("mid_rst_row", {62'd0, out_row}, 64'd0);
        chk("mid_rst_ovf", {63'd0, overflow}, 64'd0);
        rst_n = 1'b1;
        step(1);
        @(negedge clk);
        chk("post_rst_idle1", {63'd0, out_valid}, 64'd0);
        step(1);
        @(negedge clk);
        chk("post_rst_idle2", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        step(1);
        cap(2'd0, 8, 16, -8, 0, 6'd3, 1'b0, 1'b1, 1, 2, -1, 0);
        @(negedge clk);
        chk("post_rst_lat_early", {63'd0, out_valid}, 64'd0);
        step(1);
        @(negedge clk);
        chk("post_rst_lat_valid", {63'd0, out_valid}, 64'd1);
        step(4);
        @(negedge clk);
        chk("final_empty", {63'd0, out_valid}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
